vga_frame_capture: RTL and testbench
====================================

// Module: vga_frame_capture
// PURPOSE
//  Receive side of the on-chip VGA pixel stream (hs/vs/de/8-bit grey).
//  On request, captures one WIN_W x WIN_H window of a frame into the pixel RAM
//  write port in row-major order. Continuously measures line/frame periods.
//  Used for loopback self-test of the generator and for frame-grab into the framebuffer.
// PARAMETERS
//  ADDR_W     24   width of wr_addr
//  BASE_ADDR  300  RAM address of window pixel (0,0)
//  WIN_W      300  captured pixels per line (first WIN_W de-high pixels of a line)
//  WIN_H      300  captured lines per frame (first WIN_H active lines after vs)
// PORTS
//  clk           in   1       pixel clock, same domain as the video source
//  reset_n       in   1       asynchronous, active-low reset
//  arm           in   1       1-cycle request: capture the next full frame
//  vid_hs        in   1       horizontal sync, active-low
//  vid_vs        in   1       vertical sync, active-low
//  vid_de        in   1       data enable, high on active pixels
//  vid_pix       in   8       pixel value, valid when vid_de=1
//  wr_en         out  1       RAM write strobe
//  wr_addr       out  ADDR_W  RAM write address
//  wr_data       out  8       RAM write data
//  busy          out  1       high in WAIT_VS and CAPTURE
//  done          out  1       1-cycle pulse when capture ends (good or short)
//  err_short     out  1       sticky: frame ended before WIN_H lines; cleared by accepted arm
//  h_total_meas  out  12      clks between last two vid_hs falling edges
//  v_total_meas  out  12      hs falling edges between last two vid_vs falling edges
// BEHAVIOUR
//  - Reset: every output and internal register 0; FSM=IDLE.
//  - Edge detect: registered copies hs_q/vs_q/de_q; hs_fall = hs_q & ~vid_hs (same for vs);
//    de_fall = de_q & ~vid_de.
//  - x: +1 per cycle with vid_de=1; cleared on de_fall. y: +1 on de_fall; cleared on vs_fall.
//    Both 12 bits; saturate at 4095, no wrap.
//  - FSM IDLE: arm -> WAIT_VS, clear err_short. arm in any other state is ignored.
//  - WAIT_VS: vs_fall -> CAPTURE (x,y cleared the same cycle).
//  - CAPTURE: vid_de=1 & x<WIN_W & y<WIN_H -> next cycle wr_en=1,
//    wr_data=vid_pix, wr_addr=BASE_ADDR + y*WIN_W + x (ADDR_W bits, modulo 2^ADDR_W).
//    Otherwise wr_en=0; wr_addr/wr_data hold their last value.
//    Latency: fixed 1 clk from pixel sample to write strobe.
//    de_fall with y==WIN_H-1 -> DONE (the last write issues that same cycle).
//    vs_fall before that -> err_short=1, DONE; the new frame is not captured.
//  - DONE: done=1 for exactly one cycle -> IDLE.
//  - Pixels with x>=WIN_W or lines with y>=WIN_H are dropped silently.
//  - Measurement runs in every FSM state. Free-running h counter counts clks.
//    On hs_fall: h_total_meas <= h counter+1, counter <= 0.
//    Line counter +1 on each hs_fall. On vs_fall: v_total_meas <= line count, counter <= 0.
//    Both counters saturate at 4095. Outputs stay 0 until the first full period has been seen.
//  - Simultaneous hs_fall and vs_fall: both take effect; the line count
//    latched into v_total_meas includes that hs_fall.
//  - Async reset mid-capture: immediate IDLE, wr_en=0; no done pulse.
// TESTING
//  1 Generator loop: 800x525 timing, 640x480 active, pix=x^y, arm once
//    -> 90000 writes, addr 300..90299 row-major, data matches, one done, err_short=0.
//  2 Measure: same stream over 2 frames -> h_total_meas=800, v_total_meas=525.
//  3 Short frame: vs_fall after 120 active lines in CAPTURE
//    -> done pulse, err_short=1, 120*300 writes. Next arm clears err_short.
//  4 arm held during WAIT_VS/CAPTURE -> exactly one capture. arm mid-frame
//    -> writes start only after the next vs_fall.
//  5 Narrow line: de high for 200 clks -> x 0..199 written, no wrap into next row.
//    Next line starts at BASE_ADDR+300*y.
//  6 reset_n low mid-CAPTURE -> all outputs 0 immediately. Re-arm after release -> full clean capture.

Source files
------------

// File: rtl/vga_frame_capture.sv
// Receive side of the VGA pixel stream: on arm, captures one WIN_W x WIN_H window
// into the pixel RAM write port and continuously measures line/frame periods.
module vga_frame_capture #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BASE_ADDR = 300,
  parameter int unsigned WIN_W     = 300,
  parameter int unsigned WIN_H     = 300
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [7:0]        vid_pix,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic [11:0]       h_total_meas,
  output logic [11:0]       v_total_meas
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  localparam logic [11:0] W_LIM  = 12'(WIN_W);
  localparam logic [11:0] H_LIM  = 12'(WIN_H);
  localparam logic [11:0] LAST_Y = 12'(WIN_H - 1);

  state_t            state, state_nx;
  logic              hs_q, vs_q, de_q;
  logic              hs_fall, vs_fall, de_fall;
  logic [11:0]       x, y;
  logic [11:0]       h_cnt, l_cnt, l_next;
  logic              h_seen, v_seen;
  logic              capture_hit, last_line_end, short_end;
  logic [ADDR_W-1:0] pix_addr;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == '1) ? v : v + 12'd1;
  endfunction

  assign hs_fall = hs_q & ~vid_hs;
  assign vs_fall = vs_q & ~vid_vs;
  assign de_fall = de_q & ~vid_de;

  assign capture_hit   = (state == CAPTURE) && vid_de && (x < W_LIM) && (y < H_LIM);
  assign last_line_end = (state == CAPTURE) && de_fall && (y == LAST_Y);
  assign short_end     = (state == CAPTURE) && vs_fall && !last_line_end;
  assign pix_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(y) * ADDR_W'(WIN_W) + ADDR_W'(x);
  assign l_next        = hs_fall ? sat_inc(l_cnt) : l_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      hs_q <= vid_hs;
      vs_q <= vid_vs;
      de_q <= vid_de;
      // x also restarts when a capture begins so the first window line starts at column 0
      if (de_fall || (state == WAIT_VS && vs_fall)) x <= '0;
      else if (vid_de)                              x <= sat_inc(x);
      if (vs_fall)      y <= '0;
      else if (de_fall) y <= sat_inc(y);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:    if (arm) state_nx = WAIT_VS;
      WAIT_VS: begin
        busy = 1'b1;
        if (vs_fall) state_nx = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (last_line_end || short_end) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_short <= 1'b0;
    end else begin
      wr_en <= capture_hit;
      if (capture_hit) begin
        wr_addr <= pix_addr;
        wr_data <= vid_pix;
      end
      if (state == IDLE && arm) err_short <= 1'b0;
      else if (short_end)       err_short <= 1'b1;
    end
  end

  // Period outputs are only loaded once a complete period has been observed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt        <= '0;
      l_cnt        <= '0;
      h_seen       <= 1'b0;
      v_seen       <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      if (hs_fall) begin
        h_cnt  <= '0;
        h_seen <= 1'b1;
        if (h_seen) h_total_meas <= sat_inc(h_cnt);
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (vs_fall) begin
        l_cnt  <= '0;
        v_seen <= 1'b1;
        if (v_seen) v_total_meas <= l_next;
      end else begin
        l_cnt <= l_next;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: table-driven and random frame shapes, with a
// pixel-position scoreboard predicting every RAM write from the window rules.
module tb_vga_frame_capture;

  localparam int ADDR_W  = 24;
  localparam int BASE    = 300;
  localparam int WIN_W   = 12;
  localparam int WIN_H   = 8;
  localparam int V_START = 3;
  localparam int H_START = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              arm;
  logic              vid_hs, vid_vs, vid_de;
  logic [7:0]        vid_pix;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy, done, err_short;
  logic [11:0]       h_total_meas, v_total_meas;

  vga_frame_capture #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WIN_W(WIN_W), .WIN_H(WIN_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_pix(vid_pix),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_short(err_short),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h_tot; int h_act; int v_tot; int v_act; int arm_hold;
    int exp_writes; bit exp_err;
  } rec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr; logic [7:0] data; int stamp;
  } wr_t;

  wr_t  exp_q[$];
  rec_t tab[6];
  int   tests = 0, fails = 0;
  int   cyc = 0, n_wr = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wr_en) begin
        wr_t e;
        n_wr++;
        chk("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_latency", cyc - e.stamp, 1);
        end
      end
      if (done) n_done++;
    end
  end

  task automatic idle(input int n);
    arm = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // One frame: vs low for lines 0-1, hs low for clks 0-3, active area starts at
  // (H_START, V_START). cap=1 means the model expects this frame's window written.
  task automatic drive_frame(input int h_tot, input int h_act, input int v_tot,
                             input int v_act, input bit cap, input int arm_line,
                             input int arm_hold, input int abort_line);
    for (int l = 0; l < v_tot; l++) begin
      if (l == abort_line) return;
      for (int c = 0; c < h_tot; c++) begin
        int row, col;
        row     = l - V_START;
        col     = c - H_START;
        vid_vs  = (l < 2) ? 1'b0 : 1'b1;
        vid_hs  = (c < 4) ? 1'b0 : 1'b1;
        vid_de  = (row >= 0 && row < v_act && col >= 0 && col < h_act);
        vid_pix = 8'($urandom);
        arm     = (l == arm_line && c == 0) || (l < arm_hold);
        if (cap && vid_de && row < WIN_H && col < WIN_W)
          exp_q.push_back('{addr: ADDR_W'(BASE + row * WIN_W + col), data: vid_pix, stamp: cyc});
        @(posedge clk); #1;
      end
    end
    arm = 1'b0;
  endtask

  task automatic do_record(input rec_t r);
    n_wr = 0; n_done = 0;
    pulse_arm();
    drive_frame(r.h_tot, r.h_act, r.v_tot, r.v_act, 1'b1, -1, r.arm_hold, -1);
    drive_frame(r.h_tot, r.h_act, r.v_tot, r.v_act, 1'b0, -1, 0, -1);
    chk("writes", n_wr, r.exp_writes);
    chk("done_pulses", n_done, 1);
    chk("err_short", err_short, r.exp_err);
    chk("h_total_meas", h_total_meas, r.h_tot);
    chk("v_total_meas", v_total_meas, r.v_tot);
    chk("busy_idle", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_h_meas"}, h_total_meas, 0);
    chk({tag, "_v_meas"}, v_total_meas, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rec_t r;
    //            h_tot h_act v_tot v_act hold writes err
    tab[0] = '{40, 20, 16, 12, 0, 96, 1'b0};  // window fully inside active area
    tab[1] = '{30,  7, 14, 10, 0, 56, 1'b0};  // narrow line, no wrap into next row
    tab[2] = '{36, 15, 12,  5, 0, 60, 1'b1};  // short frame
    tab[3] = '{40, 20, 16, 12, 6, 96, 1'b0};  // arm held into capture; arm clears err
    tab[4] = '{24, 12, 12,  8, 0, 96, 1'b0};  // active area exactly the window
    tab[5] = '{25, 13, 11,  7, 0, 84, 1'b1};  // one line short

    reset_n = 1'b0; arm = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0; vid_pix = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(3);

    for (int i = 0; i < 6; i++) do_record(tab[i]);

    // arm mid-frame: err clears on acceptance, nothing written until next vs_fall
    n_wr = 0; n_done = 0;
    drive_frame(40, 20, 16, 12, 1'b0, 5, 0, -1);
    chk("armmid_err_cleared", err_short, 0);
    chk("armmid_busy", busy, 1);
    chk("armmid_no_early_writes", n_wr, 0);
    drive_frame(40, 20, 16, 12, 1'b1, -1, 0, -1);
    drive_frame(40, 20, 16, 12, 1'b0, -1, 0, -1);
    chk("armmid_writes", n_wr, 96);
    chk("armmid_done", n_done, 1);

    // asynchronous reset in the middle of a capture, then a clean re-capture
    n_wr = 0; n_done = 0;
    pulse_arm();
    drive_frame(40, 20, 16, 12, 1'b1, -1, 0, 6);
    chk("pre_reset_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("reset_no_done", n_done, 0);
    exp_q.delete();
    reset_n = 1'b1;
    idle(3);
    do_record(tab[0]);

    for (int i = 0; i < 6; i++) begin
      r.h_act    = $urandom_range(4, 20);
      r.h_tot    = r.h_act + $urandom_range(10, 14);
      r.v_act    = $urandom_range(3, 12);
      r.v_tot    = r.v_act + $urandom_range(4, 6);
      r.arm_hold = 0;
      r.exp_writes = ((r.v_act < WIN_H) ? r.v_act : WIN_H) * ((r.h_act < WIN_W) ? r.h_act : WIN_W);
      r.exp_err  = (r.v_act < WIN_H);
      do_record(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
